// File: rtl/note_sequencer.sv
// Score player: fetches 20-bit note words from a synchronous ROM and drives the square-wave synth.
// Optional NOTE_SEQUENCER_ARTICULATION_EN mutes the final tick of every note.
module note_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TEMPO_W = 16
) (
  input  logic               baseclk,
  input  logic               asyncrst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [TEMPO_W-1:0] tempo,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [19:0]        rom_data,
  output logic [2:0]         octave,
  output logic [3:0]         note,
  output logic [3:0]         duty,
  output logic [1:0]         effect,
  output logic               busy,
  output logic               done
);

  localparam int unsigned LEN_W = 7;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [2:0]         octave_q, octave_d;
  logic [3:0]         note_q, note_d;
  logic [3:0]         duty_q, duty_d;
  logic [1:0]         effect_q, effect_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [TEMPO_W-1:0] tick_cnt_q, tick_cnt_d;

  logic [1:0]         w_effect;
  logic [2:0]         w_octave;
  logic [3:0]         w_note;
  logic [3:0]         w_duty;
  logic [LEN_W-1:0]   w_len;
  logic [TEMPO_W-1:0] tick_limit;
  logic               tick;

  assign {w_effect, w_octave, w_note, w_duty, w_len} = rom_data;
  assign tick_limit = (tempo == '0) ? TEMPO_W'(1) : tempo;
  assign tick       = (tick_cnt_q == tick_limit);

  // Next-state and output computation; stop overrides every other transition.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    octave_d    = octave_q;
    note_d      = note_q;
    duty_d      = duty_q;
    effect_d    = effect_q;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    tick_cnt_d  = tick_cnt_q;

    if (stop) begin
      state_d  = S_IDLE;
      effect_d = 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_FETCH;
            rom_addr_d = '0;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          if (w_len == '0) begin
            if (loop_en) begin
              rom_addr_d = '0;
              state_d    = S_FETCH;
            end else begin
              effect_d = 2'b00;
              done_d   = 1'b1;
              state_d  = S_IDLE;
            end
          end else begin
            effect_d    = w_effect;
            octave_d    = w_octave;
            note_d      = w_note;
            duty_d      = w_duty;
            remaining_d = w_len;
            tick_cnt_d  = TEMPO_W'(1);
            state_d     = S_PLAY;
`ifdef NOTE_SEQUENCER_ARTICULATION_EN
            if (w_len == LEN_W'(1)) effect_d = 2'b00;
`endif
          end
        end
        S_PLAY: begin
          if (tick) begin
            tick_cnt_d = TEMPO_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              rom_addr_d = rom_addr_q + ADDR_W'(1);
              state_d    = S_FETCH;
            end else begin
              remaining_d = remaining_q - LEN_W'(1);
`ifdef NOTE_SEQUENCER_ARTICULATION_EN
              if (remaining_q == LEN_W'(2)) effect_d = 2'b00;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TEMPO_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge baseclk or posedge asyncrst) begin
    if (asyncrst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      octave_q    <= '0;
      note_q      <= '0;
      duty_q      <= '0;
      effect_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      tick_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      octave_q    <= octave_d;
      note_q      <= note_d;
      duty_q      <= duty_d;
      effect_q    <= effect_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      tick_cnt_q  <= tick_cnt_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign octave   = octave_q;
  assign note     = note_q;
  assign duty     = duty_q;
  assign effect   = effect_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Score player that drives the octave/note/duty/effect inputs of the square-wave note synthesizer.
- Fetches 20-bit note words from a synchronous score ROM and holds each note for a programmable number of tempo ticks.
- Handles end-of-score as either stop or loop.
- Sits between the CPU-side sound control registers and the synthesizer, in the same 25 MHz baseclk domain.

Parameters:
- ADDR_W, 8, score ROM address width; the score holds up to 2^ADDR_W words.
- TEMPO_W, 16, width of the tempo input (baseclk cycles per tick).

Ports:
- baseclk  in  1  25 MHz system clock.
- asyncrst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse: begin playback at address 0.
- stop  in  1  one-cycle pulse: abort playback.
- loop_en  in  1  at end-of-score: 1 = restart at address 0, 0 = finish.
- tempo  in  TEMPO_W  baseclk cycles per tick; 0 is treated as 1.
- rom_addr  out  ADDR_W  score ROM address.
- rom_data  in  20  score word. Fields: [19:18] effect, [17:15] octave, [14:11] note, [10:7] duty, [6:0] length in ticks.
- octave  out  3  to synthesizer.
- note  out  4  to synthesizer.
- duty  out  4  to synthesizer.
- effect  out  2  to synthesizer; 00 = mute.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the score ends without looping.

Behaviour:
- Reset values: rom_addr=0, octave=0, note=0, duty=0, effect=00, busy=0, done=0, FSM in IDLE. Reset mid-playback returns to these values immediately.
- ROM timing: rom_addr is registered. rom_data is valid on the cycle after rom_addr changes (1-cycle ROM latency).
- FSM states and transitions:
  - IDLE → FETCH on start; rom_addr<=0.
  - FETCH → LOAD unconditionally; this cycle covers ROM latency.
  - LOAD, length==0 (end marker):
    - loop_en=1: rom_addr<=0, go to FETCH.
    - loop_en=0: effect<=00, done<=1 for one cycle, go to IDLE.
  - LOAD, length!=0: latch effect/octave/duty/note from rom_data, remaining<=length, tick counter<=1, go to PLAY.
  - PLAY: on each tick, remaining decrements.
    - On the tick where remaining==1: rom_addr<=rom_addr+1, go to FETCH.
    - Address wraps from 2^ADDR_W-1 to 0.
- Tick generator: counts 1..max(tempo,1); tick when count equals the limit, then reloads 1.
  - Counts only in PLAY.
  - A tempo change takes effect on the next comparison.
  - If tempo drops below the current count, the tick fires when the counter wraps. This glitch is acceptable; software changes tempo only between notes.
- Note timing: note N spans length*tempo cycles in PLAY plus 2 cycles (FETCH, LOAD) of the next note.
  - Synth outputs hold their previous values during FETCH/LOAD, so there is no audible gap.
- stop: from any state, next state is IDLE with effect<=00. octave/note/duty hold. done is not pulsed.
- Simultaneous start and stop: stop wins.
- start while busy: ignored.
- loop_en is sampled only in LOAD on an end marker.
- A score with no end marker plays forever, wrapping the address.

Optional Feature:
- Macro: NOTE_SEQUENCER_ARTICULATION_EN.
- Defined:
  - During the final tick period of every note (remaining==1 in PLAY), effect is forced to 00. Repeated identical notes are therefore separated by a rest.
  - effect is restored from the next word at LOAD.
  - Notes with length==1 are silent for their whole duration.
- Undefined: effect stays as latched for the full note duration.

Test Plan:
- Reset with asyncrst asserted mid-PLAY → all outputs return to reset values within the same cycle, busy=0, rom_addr=0.
- tempo=4; ROM {effect=01, oct=3, note=9, duty=8, len=3}, {len=0}; loop_en=0; start → outputs = 01/3/9/8 from cycle 3 for 12 cycles of PLAY. rom_addr=1 fetched, then done pulses once, effect=00, busy=0.
- Same ROM with loop_en=1 → rom_addr sequence 0,1,0,1…; done never asserts; note re-latched every 16 cycles (12 PLAY + FETCH/LOAD ×2).
- tempo=0, len=2 → note lasts exactly 2 PLAY cycles (tempo treated as 1).
- ADDR_W=2, four words all len=1, no end marker → rom_addr wraps 3→0; busy stays 1; start pulses during playback have no effect.
- stop and start asserted in the same cycle during PLAY → IDLE next cycle, effect=00, done=0. A later start restarts at rom_addr=0.
- With NOTE_SEQUENCER_ARTICULATION_EN, tempo=4, len=3 → effect=01 for 8 cycles, then 00 for the last 4 cycles of the note.
